// File: rtl/i2c_slave_protocol.sv
// Byte-level I2C slave: filtered SCL/SDA, START/STOP detection, device address match,
// register pointer with auto-increment, write strobe and read serialisation. Open-drain SDA.
module i2c_slave_protocol #(
    parameter logic [6:0] I2C_ADDRESS = 7'h3D,
    parameter int         FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaOut,
    output logic [7:0] addr,
    output logic [7:0] dataIn,
    output logic       writeEn,
    input  logic [7:0] dataOut,
    output logic       busy
);
    // state      | meaning
    // IDLE       | bus ignored until START
    // DEV_ADDR   | shifting device address + R/W
    // ACK_DEV    | driving ACK for device address
    // REG_ADDR   | shifting register pointer
    // ACK_REG    | driving ACK, pointer loaded at ACK rise
    // WRITE_DATA | shifting a write byte
    // ACK_WRITE  | driving ACK, pointer advanced at ACK end
    // READ_DATA  | driving read byte MSB first
    // WAIT_MACK  | SDA released, sampling master ACK/NACK
    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_REG_ADDR, S_ACK_REG,
        S_WRITE_DATA, S_ACK_WRITE, S_READ_DATA, S_WAIT_MACK
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FILTER_LEN - 1);

    // index 0 = SCL, index 1 = SDA
    logic [1:0] r_s1, r_s2, r_filt, r_filt_d;
    logic [3:0] r_cnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= 2'b11;
            r_s2     <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_cnt[0] <= CNT_LOAD;
            r_cnt[1] <= CNT_LOAD;
        end else begin
            r_s1     <= {sdaIn, sclIn};
            r_s2     <= r_s1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_cnt[i] <= CNT_LOAD;
                end else if (r_cnt[i] == 4'd0) begin
                    r_filt[i] <= r_s2[i];
                    r_cnt[i]  <= CNT_LOAD;
                end else begin
                    r_cnt[i] <= r_cnt[i] - 4'd1;
                end
            end
        end
    end

    logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop, w_sda;
    logic [7:0] w_byte;

    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_sda_rise = r_filt[1] & ~r_filt_d[1];
    assign w_sda_fall = ~r_filt[1] & r_filt_d[1];
    assign w_start    = w_sda_fall & r_filt[0] & r_filt_d[0];
    assign w_stop     = w_sda_rise & r_filt[0] & r_filt_d[0];
    assign w_sda      = r_filt[1];

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift, r_addr, r_data_in;
    logic       r_rw, r_ack_on, r_sda_out, r_write_en, r_busy;

    assign w_byte  = {r_shift[6:0], w_sda};
    assign sdaOut  = r_sda_out;
    assign addr    = r_addr;
    assign dataIn  = r_data_in;
    assign writeEn = r_write_en;
    assign busy    = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_addr     <= 8'h00;
            r_data_in  <= 8'h00;
            r_rw       <= 1'b0;
            r_ack_on   <= 1'b0;
            r_sda_out  <= 1'b1;
            r_write_en <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            if (w_start) begin
                r_state   <= S_DEV_ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_out <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_out <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_DEV_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte[7:1] == I2C_ADDRESS) begin
                                r_state  <= S_ACK_DEV;
                                r_busy   <= 1'b1;
                                r_rw     <= w_sda;
                                r_ack_on <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_REG_ADDR, S_WRITE_DATA: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_ack_on <= 1'b0;
                            if (r_state == S_REG_ADDR) begin
                                r_state <= S_ACK_REG;
                            end else begin
                                r_state    <= S_ACK_WRITE;
                                r_data_in  <= w_byte;
                                r_write_en <= 1'b1;
                            end
                        end
                    end
                    // first sclFall starts the ACK, second sclFall ends it
                    S_ACK_DEV, S_ACK_REG, S_ACK_WRITE: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_out <= 1'b0;
                                r_ack_on  <= 1'b1;
                            end else begin
                                r_bit_cnt <= 3'd0;
                                if (r_state == S_ACK_DEV && r_rw) begin
                                    r_shift   <= dataOut;
                                    r_sda_out <= dataOut[7];
                                    r_state   <= S_READ_DATA;
                                end else begin
                                    r_sda_out <= 1'b1;
                                    r_state   <= (r_state == S_ACK_DEV) ? S_REG_ADDR : S_WRITE_DATA;
                                end
                                if (r_state == S_ACK_WRITE) r_addr <= r_addr + 8'd1;
                            end
                        end else if (w_scl_rise && r_ack_on && r_state == S_ACK_REG) begin
                            r_addr <= r_shift;
                        end
                    end
                    S_READ_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state  <= S_WAIT_MACK;
                                r_ack_on <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_out <= r_shift[6];
                        end
                    end
                    S_WAIT_MACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_out <= 1'b1;
                                r_ack_on  <= 1'b1;
                            end else begin
                                r_shift   <= dataOut;
                                r_sda_out <= dataOut[7];
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_READ_DATA;
                            end
                        end else if (w_scl_rise && r_ack_on) begin
                            if (w_sda) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_addr <= r_addr + 8'd1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_protocol.sv
// Bench for i2c_slave_protocol: bit-banged I2C master, register-interface model and
// a transaction-level reference (pointer + expected write log + expected read bytes).
module tb_i2c_slave_protocol;
    localparam int H = 24;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       glitch = 1'b0;
    logic       sdaOut, writeEn, busy;
    logic [7:0] addr, dataIn;
    logic [7:0] dataOut = 8'h00;
    wire        sda_bus = m_sda & sdaOut;

    i2c_slave_protocol #(.I2C_ADDRESS(7'h3D), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclIn(m_scl), .sdaIn(sda_bus), .sdaOut(sdaOut),
        .addr(addr), .dataIn(dataIn), .writeEn(writeEn), .dataOut(dataOut), .busy(busy)
    );

    always #5 clk = ~clk;

    // register interface: registered read data, value = addr ^ 8'h5A
    always @(posedge clk) dataOut <= addr ^ 8'h5A;

    logic [15:0] wr_log [$];
    logic [15:0] exp_wr [$];
    always @(negedge clk) if (writeEn) wr_log.push_back({addr, dataIn});

    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] ptr = 8'h00;
    logic [7:0] wbuf [8];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic low_phase(input logic b);
        if (glitch) begin
            wc(Q / 2); m_scl = 1'b1; wc(1); m_scl = 1'b0; wc(Q / 2 - 1);
        end else begin
            wc(Q);
        end
        m_sda = b;
        wc(Q);
    endtask

    task automatic high_phase();
        m_scl = 1'b1;
        if (glitch) begin
            wc(H / 2); m_scl = 1'b0; wc(1); m_scl = 1'b1; wc(H / 2 - 1);
        end else begin
            wc(H);
        end
        m_scl = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        low_phase(b);
        high_phase();
    endtask

    task automatic recv_bit(output logic b);
        low_phase(1'b1);
        m_scl = 1'b1;
        wc(H - 2);
        b = sda_bus;
        wc(2);
        m_scl = 1'b0;
    endtask

    task automatic do_start();
        wc(Q); m_sda = 1'b1; wc(Q); m_scl = 1'b1; wc(H); m_sda = 1'b0; wc(H); m_scl = 1'b0;
    endtask

    task automatic do_stop();
        wc(Q); m_sda = 1'b0; wc(Q); m_scl = 1'b1; wc(H); m_sda = 1'b1; wc(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic mack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bt);
            b[i] = bt;
        end
        send_bit(mack ? 1'b0 : 1'b1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 16'(wr_log.size()), 16'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check({tag, "_wr_entry"}, wr_log[i], exp_wr[i]);
        wr_log.delete();
        exp_wr.delete();
    endtask

    task automatic write_txn(input logic [7:0] ra, input int n, input string tag);
        logic ack;
        do_start();
        send_byte({7'h3D, 1'b0}, ack);
        check({tag, "_dev_ack"}, 16'(ack), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd1);
        send_byte(ra, ack);
        check({tag, "_reg_ack"}, 16'(ack), 16'd0);
        ptr = ra;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            check({tag, "_data_ack"}, 16'(ack), 16'd0);
            exp_wr.push_back({ptr, wbuf[i]});
            ptr = ptr + 8'd1;
        end
        do_stop();
        check({tag, "_busy_end"}, 16'(busy), 16'd0);
        check({tag, "_addr"}, 16'(addr), 16'(ptr));
        check_writes(tag);
    endtask

    task automatic read_txn(input logic [7:0] ra, input int n, input string tag);
        logic ack;
        logic [7:0] b;
        do_start();
        send_byte({7'h3D, 1'b0}, ack);
        send_byte(ra, ack);
        check({tag, "_reg_ack"}, 16'(ack), 16'd0);
        ptr = ra;
        do_start();
        send_byte({7'h3D, 1'b1}, ack);
        check({tag, "_dev_ack"}, 16'(ack), 16'd0);
        for (int i = 0; i < n; i++) begin
            recv_byte(b, i != n - 1);
            check({tag, "_rdata"}, 16'(b), 16'(ptr ^ 8'h5A));
            if (i != n - 1) ptr = ptr + 8'd1;
        end
        check({tag, "_nack_sda"}, 16'(sdaOut), 16'd1);
        check({tag, "_nack_busy"}, 16'(busy), 16'd0);
        do_stop();
        check({tag, "_addr"}, 16'(addr), 16'(ptr));
        check_writes(tag);
    endtask

    initial begin : main
        logic ack;
        logic [7:0] ra;
        wc(5);
        rst_n = 1'b1;
        wc(5);
        check("rst_sda", 16'(sdaOut), 16'd1);
        check("rst_addr", 16'(addr), 16'd0);
        check("rst_datain", 16'(dataIn), 16'd0);
        check("rst_we", 16'(writeEn), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);

        wbuf[0] = 8'h01;
        write_txn(8'h81, 1, "single");

        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
        write_txn(8'hFE, 3, "burst");
        check("burst_wrap_addr", 16'(addr), 16'h0001);

        read_txn(8'hB0, 3, "read");

        ra = addr;
        do_start();
        send_byte({7'h3C, 1'b0}, ack);
        check("mism_dev_ack", 16'(ack), 16'd1);
        check("mism_busy", 16'(busy), 16'd0);
        send_byte(8'h55, ack);
        check("mism_b1_ack", 16'(ack), 16'd1);
        send_byte(8'h66, ack);
        check("mism_b2_ack", 16'(ack), 16'd1);
        do_stop();
        check("mism_addr", 16'(addr), 16'(ra));
        check_writes("mism");

        glitch = 1'b1;
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        write_txn(8'($urandom), 3, "glitch");
        glitch = 1'b0;

        ra = 8'($urandom);
        write_txn(ra, 0, "zero_data");

        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            write_txn(8'($urandom), n, "rand_wr");
            read_txn(8'($urandom), $urandom_range(1, 4), "rand_rd");
        end

        ra = 8'($urandom) | 8'h01;
        do_start();
        send_byte({7'h3D, 1'b0}, ack);
        send_byte(ra, ack);
        check("abort_reg_ack", 16'(ack), 16'd0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        do_stop();
        check("abort_sda", 16'(sdaOut), 16'd1);
        check("abort_addr", 16'(addr), 16'(ra));
        check_writes("abort");

        do_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (7'h3D >> (i - 1)) & 1'b1);
        wc(Q);
        m_sda = 1'b1;
        check("rstmid_ack_drv", 16'(sdaOut), 16'd0);
        check("rstmid_busy_pre", 16'(busy), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_sda", 16'(sdaOut), 16'd1);
        check("rstmid_addr", 16'(addr), 16'd0);
        check("rstmid_datain", 16'(dataIn), 16'd0);
        check("rstmid_we", 16'(writeEn), 16'd0);
        check("rstmid_busy", 16'(busy), 16'd0);
        wc(3);
        rst_n = 1'b1;
        ptr = 8'h00;
        wc(Q);
        high_phase();
        send_byte(8'($urandom), ack);
        check("rstmid_post_ack", 16'(ack), 16'd1);
        send_byte(8'($urandom), ack);
        do_stop();
        check("rstmid_post_addr", 16'(addr), 16'(ptr));
        check("rstmid_post_busy", 16'(busy), 16'd0);
        check_writes("rstmid");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
